// File: rtl/uart_tx_parity_gen.sv
// Parity generator/checker for the UART TX path: captures a word, holds its parity bit
// for the whole frame and verifies the bits the serializer actually shifts out.
module uart_tx_parity_gen #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_en,
    input  logic [1:0]            par_mode,
    input  logic                  frame_done,
    input  logic                  ser_en,
    input  logic                  ser_data,
    input  logic                  clr_err,
    output logic                  par_bit,
    output logic                  par_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  chk_err
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic              raw_q, raw_d;
    logic              par_en_q, par_en_d;
    logic [1:0]        par_mode_q, par_mode_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              par_bit_q, par_bit_d;
    logic              par_valid_q, par_valid_d;
    logic              overrun_q, overrun_d;
    logic              chk_err_q, chk_err_d;
    logic              capture;
    logic              chk_set;
    logic              ovr_set;

    // Map raw parity and mode onto the transmitted parity bit.
    function automatic logic sel_par(input logic raw, input logic en, input logic [1:0] mode);
        logic p;
        case (mode)
            2'b00:   p = raw;
            2'b01:   p = ~raw;
            2'b10:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return en & p;
    endfunction

    // Next-state: frame lock, serial accumulation, error detection and capture.
    always_comb begin
        state_d     = state_q;
        raw_d       = raw_q;
        par_en_d    = par_en_q;
        par_mode_d  = par_mode_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        par_bit_d   = par_bit_q;
        capture     = 1'b0;
        chk_set     = 1'b0;
        ovr_set     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (data_valid) begin
                    capture = 1'b1;
                end
            end
            StHold: begin
                if (ser_en) begin
                    if (cnt_q == CntFull) begin
                        // Long frame: counter saturates.
                        chk_set = 1'b1;
                    end else begin
                        acc_d = acc_q ^ ser_data;
                        cnt_d = cnt_q + CntOne;
                        // Raw parity compare works regardless of mode or enable.
                        if (cnt_q == CntLast && (acc_q ^ ser_data) != raw_q) begin
                            chk_set = 1'b1;
                        end
                    end
                end
                if (frame_done) begin
                    if (cnt_q != CntFull) begin
                        chk_set = 1'b1;
                    end
                    if (data_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (data_valid) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            state_d    = StHold;
            raw_d      = ^data;
            par_en_d   = par_en;
            par_mode_d = par_mode;
            cnt_d      = '0;
            acc_d      = 1'b0;
            par_bit_d  = sel_par(^data, par_en, par_mode);
        end

        par_valid_d = (state_d == StHold) & par_en_d;
        // Sticky flags: a set in the same cycle wins over clear.
        chk_err_d   = chk_set | (chk_err_q & ~clr_err);
        overrun_d   = ovr_set | (overrun_q & ~clr_err);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            raw_q       <= 1'b0;
            par_en_q    <= 1'b0;
            par_mode_q  <= 2'b00;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            par_bit_q   <= 1'b0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            chk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            raw_q       <= raw_d;
            par_en_q    <= par_en_d;
            par_mode_q  <= par_mode_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            par_bit_q   <= par_bit_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
            chk_err_q   <= chk_err_d;
        end
    end

    assign par_bit   = par_bit_q;
    assign par_valid = par_valid_q;
    assign busy      = (state_q == StHold);
    assign overrun   = overrun_q;
    assign chk_err   = chk_err_q;

endmodule

// File: tb/tb_uart_tx_parity_gen.sv
// Bench for uart_tx_parity_gen: directed plan cases plus randomized frames, all checked
// against a frame-level reference model (8-bit instance) and constants (5-bit instance).
module tb_uart_tx_parity_gen;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance signals
    logic         a_dv = 0, a_pe = 0, a_fd = 0, a_se = 0, a_sd = 0, a_ce = 0;
    logic [7:0]   a_d = '0;
    logic [1:0]   a_pm = '0;
    logic         a_pb, a_pv, a_busy, a_ovr, a_chk;

    // 5-bit instance signals
    logic         b_dv = 0, b_pe = 0, b_fd = 0, b_se = 0, b_sd = 0, b_ce = 0;
    logic [4:0]   b_d = '0;
    logic [1:0]   b_pm = '0;
    logic         b_pb, b_pv, b_busy, b_ovr, b_chk;

    uart_tx_parity_gen #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .data_valid(a_dv), .data(a_d), .par_en(a_pe),
        .par_mode(a_pm), .frame_done(a_fd), .ser_en(a_se), .ser_data(a_sd), .clr_err(a_ce),
        .par_bit(a_pb), .par_valid(a_pv), .busy(a_busy), .overrun(a_ovr), .chk_err(a_chk)
    );

    uart_tx_parity_gen #(.DATA_WIDTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .data_valid(b_dv), .data(b_d), .par_en(b_pe),
        .par_mode(b_pm), .frame_done(b_fd), .ser_en(b_se), .ser_data(b_sd), .clr_err(b_ce),
        .par_bit(b_pb), .par_valid(b_pv), .busy(b_busy), .overrun(b_ovr), .chk_err(b_chk)
    );

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame-level view of what the block should report.
    logic       m_busy, m_en, m_par, m_ovr, m_chk;
    logic [1:0] m_mode;
    logic [7:0] m_word;
    int         m_nbits, m_ones;

    function automatic logic word_par(input logic [7:0] w);
        return logic'($countones(w) % 2);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_en = 0; m_par = 0; m_ovr = 0; m_chk = 0;
        m_mode = 0; m_word = 0; m_nbits = 0; m_ones = 0;
    endtask

    task automatic model_capture(input logic [7:0] d, input logic pe, input logic [1:0] pm);
        m_busy = 1; m_word = d; m_en = pe; m_mode = pm; m_nbits = 0; m_ones = 0;
        if (!pe)            m_par = 0;
        else if (pm == 2'd0) m_par = word_par(d);
        else if (pm == 2'd1) m_par = ~word_par(d);
        else if (pm == 2'd2) m_par = 1;
        else                 m_par = 0;
    endtask

    task automatic model_step();
        logic ev_chk = 0, ev_ovr = 0;
        int   nb0 = m_nbits;
        if (m_busy) begin
            if (a_se) begin
                if (m_nbits == W) ev_chk = 1;
                else begin
                    m_nbits++;
                    m_ones += int'(a_sd);
                    if (m_nbits == W && logic'(m_ones % 2) != word_par(m_word)) ev_chk = 1;
                end
            end
            if (a_fd) begin
                if (nb0 != W) ev_chk = 1;
                if (a_dv) model_capture(a_d, a_pe, a_pm);
                else m_busy = 0;
            end else if (a_dv) ev_ovr = 1;
        end else if (a_dv) begin
            model_capture(a_d, a_pe, a_pm);
        end
        m_chk = ev_chk | (m_chk & ~a_ce);
        m_ovr = ev_ovr | (m_ovr & ~a_ce);
    endtask

    task automatic check_model(input string where);
        check_val({where, ".par_bit"},   32'(a_pb),   32'(m_par));
        check_val({where, ".par_valid"}, 32'(a_pv),   32'(m_busy & m_en));
        check_val({where, ".busy"},      32'(a_busy), 32'(m_busy));
        check_val({where, ".overrun"},   32'(a_ovr),  32'(m_ovr));
        check_val({where, ".chk_err"},   32'(a_chk),  32'(m_chk));
    endtask

    // One clock of stimulus on the 8-bit instance, then model update and compare.
    task automatic cyc(input logic dv, input logic [7:0] d, input logic pe, input logic [1:0] pm,
                       input logic fd, input logic se, input logic sd, input logic ce);
        a_dv = dv; a_d = d; a_pe = pe; a_pm = pm; a_fd = fd; a_se = se; a_sd = sd; a_ce = ce;
        @(posedge clk);
        #1;
        model_step();
        check_model("cyc");
        a_dv = 0; a_fd = 0; a_se = 0; a_sd = 0; a_ce = 0;
    endtask

    task automatic capture(input logic [7:0] d, input logic pe, input logic [1:0] pm);
        cyc(1, d, pe, pm, 0, 0, 0, 0);
    endtask

    // Shift n bits of w LSB-first starting at bit 'start', xor'ed with flip mask.
    task automatic send_bits(input logic [7:0] w, input int start, input int n,
                             input logic [8:0] flip);
        logic [8:0] ww;
        ww = {1'b0, w} ^ flip;
        for (int i = start; i < start + n; i++) cyc(0, 0, 0, 0, 0, 1, ww[i], 0);
    endtask

    task automatic done_frame();
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic b_cyc(input logic dv, input logic [4:0] d, input logic fd, input logic se,
                         input logic sd);
        b_dv = dv; b_d = d; b_pe = 1; b_pm = 2'd0; b_fd = fd; b_se = se; b_sd = sd;
        @(posedge clk);
        #1;
        b_dv = 0; b_fd = 0; b_se = 0; b_sd = 0;
    endtask

    initial begin
        logic [7:0] w;
        logic [4:0] bw;
        logic       pb_hold;
        model_reset();
        #12;
        check_val("rst.par_bit", 32'(a_pb), 0);
        check_val("rst.busy", 32'(a_busy), 0);
        check_val("rst.flags", 32'({a_pv, a_ovr, a_chk}), 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Modes
        capture(8'hA5, 1, 2'd0); check_val("a5_even", 32'(a_pb), 0);
        check_val("a5_even_pv", 32'(a_pv), 1);
        send_bits(8'hA5, 0, 8, 0); done_frame();
        capture(8'hA5, 1, 2'd1); check_val("a5_odd", 32'(a_pb), 1);
        send_bits(8'hA5, 0, 8, 0); done_frame();
        capture(8'h07, 1, 2'd0); check_val("07_even", 32'(a_pb), 1);
        send_bits(8'h07, 0, 8, 0); done_frame();
        capture(8'h07, 1, 2'd2); check_val("mark", 32'(a_pb), 1);
        send_bits(8'h07, 0, 8, 0); done_frame();
        capture(8'h07, 1, 2'd3); check_val("space", 32'(a_pb), 0);
        send_bits(8'h07, 0, 8, 0); done_frame();
        capture(8'h07, 0, 2'd0);
        check_val("noen", 32'({a_pb, a_pv, a_busy}), 32'b001);
        send_bits(8'h07, 0, 8, 0); done_frame();

        // Serial check
        capture(8'hA5, 1, 2'd0); send_bits(8'hA5, 0, 8, 0);
        check_val("ser_ok", 32'(a_chk), 0);
        done_frame();
        capture(8'hA5, 1, 2'd0); send_bits(8'hA5, 0, 8, 9'h008);
        check_val("ser_flip", 32'(a_chk), 1);
        done_frame();
        cyc(0, 0, 0, 0, 0, 0, 0, 1); check_val("clr", 32'(a_chk), 0);

        // Frame length errors
        capture(8'h5A, 1, 2'd0); send_bits(8'h5A, 0, 7, 0); done_frame();
        check_val("short_chk", 32'(a_chk), 1);
        check_val("short_busy", 32'(a_busy), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        capture(8'h5A, 1, 2'd0); send_bits(8'h5A, 0, 8, 0);
        check_val("long_pre", 32'(a_chk), 0);
        send_bits(8'h5A, 8, 1, 0); check_val("long_chk", 32'(a_chk), 1);
        done_frame(); cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Overrun and back-to-back
        capture(8'h81, 1, 2'd1); pb_hold = a_pb; send_bits(8'h81, 0, 3, 0);
        cyc(1, 8'h3C, 1, 2'd0, 0, 0, 0, 0);
        check_val("ovr", 32'(a_ovr), 1);
        check_val("ovr_pb", 32'(a_pb), 32'(pb_hold));
        send_bits(8'h81, 3, 5, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 8'h01, 1, 2'd0, 1, 0, 0, 0);
        check_val("b2b", 32'({a_busy, a_pb, a_ovr}), 32'b110);
        send_bits(8'h01, 0, 8, 0); done_frame();

        // Reset mid-frame
        capture(8'hC3, 1, 2'd1); send_bits(8'hC3, 0, 4, 0);
        rst_n = 0;
        #1;
        check_val("midrst", 32'({a_pb, a_pv, a_busy, a_ovr, a_chk}), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        capture(8'hFF, 1, 2'd1);
        check_val("ff_odd", 32'({a_pb, a_ovr, a_chk}), 32'b100);
        send_bits(8'hFF, 0, 8, 0); done_frame();

        // Randomized frames against the model
        for (int f = 0; f < 80; f++) begin
            int   nb, flip_at;
            w = 8'($urandom);
            capture(w, logic'($urandom_range(0, 3) != 0), 2'($urandom));
            nb = W;
            if ($urandom_range(0, 5) == 0) nb = ($urandom_range(0, 1) != 0) ? W + 1 : W - 1;
            flip_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            for (int i = 0; i < nb; i++) begin
                logic b;
                b = (i < W) ? w[i] : logic'($urandom);
                if (i == flip_at) b = ~b;
                if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 0, 0, 0, 0);
                cyc(logic'($urandom_range(0, 9) == 0), 8'($urandom), 1, 2'd0, 0, 1, b,
                    logic'($urandom_range(0, 9) == 0));
            end
            cyc(0, 0, 0, 0, 1, logic'($urandom_range(0, 7) == 0), 0, 0);
            // Stray serializer activity while idle must be ignored.
            cyc(0, 0, 0, 0, logic'($urandom), logic'($urandom), 1,
                logic'($urandom_range(0, 2) == 0));
        end

        // 5-bit width instance
        bw = 5'b10110;
        b_cyc(1, bw, 0, 0, 0);
        check_val("w5_par", 32'(b_pb), 1);
        check_val("w5_busy", 32'({b_busy, b_pv}), 32'b11);
        for (int i = 0; i < 5; i++) b_cyc(0, 0, 0, 1, bw[i]);
        check_val("w5_chk", 32'(b_chk), 0);
        b_cyc(0, 0, 1, 0, 0);
        check_val("w5_end", 32'({b_busy, b_chk, b_ovr}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_parity_gen.md
# uart_tx_parity_gen

Parametrised parity generator and checker for the UART transmit path, the successor to the fixed 8-bit even/odd parity calculator. It sits between the TX front end and the TX serializer/FSM. It captures a data word, generates the parity bit in one of four modes, and holds it stable for the whole frame. It also recomputes parity from the bits the serializer actually shifts out and flags overruns, short or long frames, and serial corruption.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- DATA_VALID  in  1  capture request for DATA.
- DATA  in  DATA_WIDTH  word to transmit.
- PAR_EN  in  1  parity enable, sampled at capture.
- PAR_MODE  in  2  parity mode, sampled at capture: 00 even, 01 odd, 10 mark (1), 11 space (0).
- FRAME_DONE  in  1  single-cycle pulse from the TX FSM at the end of the stop bit.
- SER_EN  in  1  serializer is shifting a data bit this cycle.
- SER_DATA  in  1  data bit being shifted, qualified by SER_EN.
- CLR_ERR  in  1  clears the sticky error flags.
- PAR_BIT  out  1  parity bit for the current frame.
- PAR_VALID  out  1  PAR_BIT is valid and the frame uses parity.
- BUSY  out  1  a frame is locked.
- OVERRUN  out  1  sticky: DATA_VALID arrived while BUSY.
- CHK_ERR  out  1  sticky: the serialized bits disagree with the captured word, or the bit count is wrong.

## Operation
- Two states: IDLE and HOLD. Internal registers:
  - raw parity latch R (^DATA)
  - latched PAR_EN and PAR_MODE
  - bit counter C, width $clog2(DATA_WIDTH+1)
  - serial accumulator S
- **IDLE with DATA_VALID:**
  - Latch R, PAR_EN and PAR_MODE; clear C and S; go to HOLD.
  - PAR_BIT becomes: even R, odd ~R, mark 1, space 0. If the latched PAR_EN is 0, PAR_BIT is 0.
- **IDLE otherwise:** SER_EN and FRAME_DONE are ignored and no flag is set. PAR_BIT keeps its last value.
- **HOLD:**
  - Each SER_EN: S ^= SER_DATA and C increments.
  - On the SER_EN that brings C to DATA_WIDTH: if (S ^ SER_DATA) != R, set CHK_ERR. The comparison uses raw parity, so it works in every mode and with PAR_EN=0.
  - SER_EN when C == DATA_WIDTH: set CHK_ERR (long frame). C saturates.
- **HOLD with FRAME_DONE:**
  - If C != DATA_WIDTH, set CHK_ERR (short frame).
  - Without DATA_VALID: go to IDLE.
  - With DATA_VALID in the same cycle: capture the new word as in IDLE and stay in HOLD. This is a back-to-back frame and is not an overrun.
- **HOLD with DATA_VALID and no FRAME_DONE:** set OVERRUN. DATA is discarded and the latched values are untouched.
- **BUSY** = (state == HOLD). **PAR_VALID** = BUSY & latched PAR_EN.
- **CLR_ERR:** clears OVERRUN and CHK_ERR. If an error event occurs in the same cycle, the set wins.
- **DATA_WIDTH < 9:** upper DATA bits do not exist. Parity covers exactly DATA_WIDTH bits.

## Timing
- **Reset (asynchronous, RST low):**
  - state IDLE
  - PAR_BIT, PAR_VALID, BUSY, OVERRUN, CHK_ERR all 0
  - R, S and C cleared
- **Reset mid-frame:** the frame is abandoned. No flag is set.
- All outputs are registered.
- **Capture latency:** PAR_BIT, PAR_VALID and BUSY are valid in the first cycle after the capturing edge. They stay constant until the edge that processes FRAME_DONE.
- **Release:** BUSY and PAR_VALID fall in the cycle after the FRAME_DONE edge. On a back-to-back capture they stay high, and PAR_BIT updates in that same cycle.
- **Flag latency:** CHK_ERR and OVERRUN rise in the cycle after the detecting edge.
- **Throughput:** one frame per FRAME_DONE. There is no minimum gap.
- DATA_VALID is a one-cycle strobe. It is ignored when high for several cycles in IDLE only after the first capture; subsequent cycles in HOLD count as overrun.

## Test plan
All scenarios use DATA_WIDTH=8 unless stated.

1. **Modes:**
   - DATA=0xA5, even -> PAR_BIT=0, PAR_VALID=1 one cycle after capture.
   - Odd -> PAR_BIT=1.
   - DATA=0x07, even -> PAR_BIT=1.
   - Mark -> 1; space -> 0.
   - PAR_EN=0 -> PAR_BIT=0, PAR_VALID=0, BUSY=1.
2. **Serial check:**
   - Capture 0xA5, then 8 SER_EN pulses carrying the LSB-first bits -> CHK_ERR stays 0.
   - Repeat with bit 3 flipped -> CHK_ERR=1 after the 8th pulse.
   - Assert CLR_ERR -> CHK_ERR=0.
3. **Frame length errors:**
   - FRAME_DONE after 7 SER_EN -> CHK_ERR=1, BUSY=0 next cycle.
   - 9 SER_EN -> CHK_ERR=1 after the 9th pulse.
4. **Overrun and back-to-back:**
   - DATA_VALID with 0x3C mid-frame -> OVERRUN=1, PAR_BIT unchanged.
   - FRAME_DONE together with DATA_VALID carrying 0x01 (even) -> BUSY stays 1, PAR_BIT=1, OVERRUN not set.
5. **Reset mid-frame:** drop RST after 4 SER_EN -> all outputs 0 immediately. After release, a new capture of 0xFF (odd) -> PAR_BIT=1 with no error flags.
6. **Width parameter:** DATA_WIDTH=5, DATA=5'b10110, even -> PAR_BIT=1. Exactly 5 SER_EN pulses with matching bits -> no CHK_ERR.
